fetch_buffer: RTL and testbench
===============================

FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 The block SHALL have parameter FETCH_WIDTH, default `FETCH_WIDTH, instructions per fetch bundle (>=1).
REQ-002 The block SHALL have parameter INST_ADDR_WIDTH, default `INST_ADDR_WIDTH, instruction address width.
REQ-003 The block SHALL have parameter DEPTH, default 4, bundle entries; power of two, >=2.
REQ-004 The block SHALL have one clock and a synchronous active-high reset, with ports as follows:
- clk  input  1  clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  discard all entries (redirect/mispredict).
- in_valid  input  1  producer bundle valid.
- in_ready  output  1  buffer accepts a bundle this cycle.
- in_inst  input  32 x FETCH_WIDTH  instruction words of the bundle.
- in_slot_valid  input  FETCH_WIDTH  per-slot instruction valid mask.
- in_pc  input  INST_ADDR_WIDTH  PC of slot 0.
- in_pc_plus_4  input  INST_ADDR_WIDTH  PC+4 of slot 0.
- out_valid  output  1  head bundle valid.
- out_ready  input  1  consumer takes head bundle.
- out_inst  output  32 x FETCH_WIDTH  head instruction words.
- out_slot_valid  output  FETCH_WIDTH  head slot mask.
- out_pc  output  INST_ADDR_WIDTH  head PC.
- out_pc_plus_4  output  INST_ADDR_WIDTH  head PC+4.
- count  output  clog2(DEPTH+1)  occupied entries.

Function
REQ-005 The block SHALL store whole bundles (inst, slot mask, pc, pc_plus_4) in a circular FIFO of DEPTH entries with wr_ptr/rd_ptr of clog2(DEPTH) bits wrapping DEPTH-1 -> 0.
REQ-006 in_ready SHALL equal (count < DEPTH) && !flush; it SHALL NOT depend on out_ready (no full-bypass).
REQ-007 Push SHALL occur when in_valid && in_ready: entry written at wr_ptr, wr_ptr+1.
REQ-008 Pop SHALL occur when out_valid && out_ready && !flush: rd_ptr+1.
REQ-009 out_valid SHALL equal (count != 0); out_* fields SHALL be driven from the entry at rd_ptr (registered storage, no combinational path from in_* to out_*).
REQ-010 Latency SHALL be one cycle: a bundle pushed at edge N is visible at the output with out_valid=1 after edge N.
REQ-011 Simultaneous push and pop SHALL leave count unchanged and advance both pointers; legal when count is 1..DEPTH-1.
REQ-012 count SHALL increment on push-only, decrement on pop-only, and never exceed DEPTH or go below 0.
REQ-013 Bundles SHALL leave in push order; contents SHALL be unchanged while resident.
REQ-014 A bundle with in_slot_valid == 0 SHALL NOT be pushed (in_ready still reported; bundle dropped).
REQ-015 flush SHALL take priority over push and pop: after the flush edge count=0, wr_ptr=rd_ptr=0, out_valid=0; storage contents need not be cleared.
REQ-016 out_inst/out_slot_valid/out_pc/out_pc_plus_4 SHALL be don't-care when out_valid=0, except as fixed by REQ-018.
REQ-017 Pop on empty and push on full SHALL be ignored without state change.

Reset
REQ-018 On reset high at an edge: count=0, pointers=0, all storage entries zeroed; hence out_valid=0, in_ready=0 during reset, out_* fields=0 after reset.
REQ-019 reset SHALL take priority over flush, push and pop; reset mid-operation discards all entries.
REQ-020 in_ready SHALL be 0 while reset is asserted and 1 on the first cycle after release.

Verification (DEPTH=4, FETCH_WIDTH=2, INST_ADDR_WIDTH=32)
REQ-021 Reset then idle -> out_valid=0, count=0, in_ready=1, out_pc=0x0.
REQ-022 Push pc=0x100,0x108,0x110,0x118 with out_ready=0 -> count=4, in_ready=0; 5th bundle pc=0x120 not accepted; then out_ready=1 pops 0x100,0x108,0x110,0x118 in order, one per cycle.
REQ-023 count=2, in_valid=1 and out_ready=1 for 6 cycles -> count stays 2, pointers wrap past 3, output order equals push order.
REQ-024 count=3, flush=1 with in_valid=1 (pc=0x200) -> next cycle count=0, out_valid=0, 0x200 absent; push 0x300 next -> out_pc=0x300 one cycle later.
REQ-025 Push bundle with in_slot_valid=2'b00 -> count unchanged; push in_slot_valid=2'b10, inst={0x00000013,0x00100093} -> out_slot_valid=2'b10, words preserved.
REQ-026 count=3, assert reset for one cycle -> count=0, out_valid=0, out_pc=0x0, in_ready=1 next cycle.

Source files
------------

// File: rtl/fetch_buffer.sv
`ifndef FETCH_WIDTH
`define FETCH_WIDTH 2
`endif
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif

`default_nettype none

// ============================================================================
//  Module      : fetch_buffer
//  Description : Circular FIFO of whole fetch bundles (instruction words,
//                per-slot valid mask, PC and PC+4) between the fetch stage
//                and decode. Registered outputs, one-cycle latency, flush
//                support for redirects.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_buffer #(
    parameter int FETCH_WIDTH     = `FETCH_WIDTH,
    parameter int INST_ADDR_WIDTH = `INST_ADDR_WIDTH,
    parameter int DEPTH           = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    // producer side
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [32*FETCH_WIDTH-1:0]     in_inst,
    input  logic [FETCH_WIDTH-1:0]        in_slot_valid,
    input  logic [INST_ADDR_WIDTH-1:0]    in_pc,
    input  logic [INST_ADDR_WIDTH-1:0]    in_pc_plus_4,
    // consumer side
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [32*FETCH_WIDTH-1:0]     out_inst,
    output logic [FETCH_WIDTH-1:0]        out_slot_valid,
    output logic [INST_ADDR_WIDTH-1:0]    out_pc,
    output logic [INST_ADDR_WIDTH-1:0]    out_pc_plus_4,
    // occupancy
    output logic [$clog2(DEPTH+1)-1:0]    count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int INST_W = 32 * FETCH_WIDTH;

    localparam logic [CNT_W-1:0] c_DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0] c_PTR_ONE   = PTR_W'(1);

    // Bundle storage, one field array per bundle component
    logic [INST_W-1:0]          r_inst_mem [DEPTH];
    logic [FETCH_WIDTH-1:0]     r_slot_mem [DEPTH];
    logic [INST_ADDR_WIDTH-1:0] r_pc_mem   [DEPTH];
    logic [INST_ADDR_WIDTH-1:0] r_pc4_mem  [DEPTH];

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_push;
    logic w_pop;
    logic w_not_full;
    logic w_bundle_has_inst;

    // Handshake decode: empty-mask bundles are acknowledged but never stored,
    // and a flush suppresses both ends so the redirect edge only clears state.
    always_comb begin
        w_not_full        = (r_count < c_DEPTH_CNT);
        w_bundle_has_inst = (in_slot_valid != '0);
        in_ready          = !reset && !flush && w_not_full;
        out_valid         = (r_count != '0);
        w_push            = in_valid && in_ready && w_bundle_has_inst;
        w_pop             = out_valid && out_ready && !flush;
    end

    // Storage write: zeroed on reset, otherwise written at the tail on push
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_inst_mem[i] <= '0;
                r_slot_mem[i] <= '0;
                r_pc_mem[i]   <= '0;
                r_pc4_mem[i]  <= '0;
            end
        end else if (w_push) begin
            r_inst_mem[r_wr_ptr] <= in_inst;
            r_slot_mem[r_wr_ptr] <= in_slot_valid;
            r_pc_mem[r_wr_ptr]   <= in_pc;
            r_pc4_mem[r_wr_ptr]  <= in_pc_plus_4;
        end
    end

    // Pointer and occupancy tracking; reset and flush both empty the queue
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_ONE;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_CNT_ONE;
            end
        end
    end

    // Head bundle is read straight out of registered storage
    always_comb begin
        out_inst       = r_inst_mem[r_rd_ptr];
        out_slot_valid = r_slot_mem[r_rd_ptr];
        out_pc         = r_pc_mem[r_rd_ptr];
        out_pc_plus_4  = r_pc4_mem[r_rd_ptr];
        count          = r_count;
    end

endmodule

`default_nettype wire

// File: tb/tb_fetch_buffer.sv
`default_nettype none

// ============================================================================
//  Module      : tb_fetch_buffer
//  Description : Scoreboard bench for fetch_buffer. The driver predicts which
//                bundles are accepted and queues them; the monitor retires
//                queue entries on observed pops and compares the DUT head,
//                occupancy and handshakes against the queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_buffer;

    localparam int FW    = 2;
    localparam int AW    = 32;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [32*FW-1:0] inst;
        logic [FW-1:0]    mask;
        logic [AW-1:0]    pc;
        logic [AW-1:0]    pc4;
    } bundle_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [32*FW-1:0]  in_inst = '0;
    logic [FW-1:0]     in_slot_valid = '0;
    logic [AW-1:0]     in_pc = '0;
    logic [AW-1:0]     in_pc_plus_4 = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [32*FW-1:0]  out_inst;
    logic [FW-1:0]     out_slot_valid;
    logic [AW-1:0]     out_pc;
    logic [AW-1:0]     out_pc_plus_4;
    logic [2:0]        count;

    bundle_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    bit  armed = 0;
    bit  clean = 0;
    bit  prev_nonempty = 0;

    fetch_buffer #(.FETCH_WIDTH(FW), .INST_ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
        .in_slot_valid(in_slot_valid), .in_pc(in_pc), .in_pc_plus_4(in_pc_plus_4),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_slot_valid(out_slot_valid), .out_pc(out_pc),
        .out_pc_plus_4(out_pc_plus_4), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    // Driver: applies one cycle of stimulus and queues the bundle if the
    // buffer is expected to store it at the coming edge.
    task automatic step(input bit rst, input bit fl, input bit iv, input logic [1:0] m,
                        input logic [63:0] inst, input logic [31:0] pc, input bit ordy);
        bundle_t b;
        @(negedge clk);
        #1;
        reset         = rst;
        flush         = fl;
        in_valid      = iv;
        in_slot_valid = m;
        in_inst       = inst;
        in_pc         = pc;
        in_pc_plus_4  = pc + 32'd4;
        out_ready     = ordy;
        if (iv && !rst && !fl && (m != 2'b00) && (exp_q.size() < DEPTH)) begin
            b.inst = inst; b.mask = m; b.pc = pc; b.pc4 = pc + 32'd4;
            exp_q.push_back(b);
            clean = 0;
        end
    endtask

    task automatic idle(input int n, input bit ordy);
        for (int k = 0; k < n; k++) step(0, 0, 0, 2'b00, 64'h0, 32'h0, ordy);
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    // Monitor: at each falling edge, first account for what the previous
    // rising edge did (reset/flush/pop), then compare the DUT against the queue.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_q.delete();
                armed = 1;
                clean = 1;
            end else if (armed) begin
                if (flush) exp_q.delete();
                else if (prev_nonempty && out_ready) void'(exp_q.pop_front());
            end
            if (armed) begin
                chk("count", 64'(count), 64'(exp_q.size()));
                chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
                chk("in_ready", 64'(in_ready),
                    64'(!reset && !flush && (exp_q.size() < DEPTH)));
                if (exp_q.size() != 0) begin
                    chk("head_pc", 64'(out_pc), 64'(exp_q[0].pc));
                    chk("head_pc4", 64'(out_pc_plus_4), 64'(exp_q[0].pc4));
                    chk("head_inst", out_inst, exp_q[0].inst);
                    chk("head_mask", 64'(out_slot_valid), 64'(exp_q[0].mask));
                end else if (clean) begin
                    chk("reset_pc", 64'(out_pc), 64'h0);
                    chk("reset_pc4", 64'(out_pc_plus_4), 64'h0);
                    chk("reset_inst", out_inst, 64'h0);
                    chk("reset_mask", 64'(out_slot_valid), 64'h0);
                end
                prev_nonempty = (exp_q.size() != 0);
            end
        end
    end

    initial begin
        // reset, then idle
        for (int k = 0; k < 3; k++) step(1, 0, 0, 2'b00, 64'h0, 32'h0, 0);
        idle(2, 0);

        // fill to full, attempt a fifth push, then drain in order
        for (int k = 0; k < 4; k++) step(0, 0, 1, 2'b11, rnd64(), 32'h100 + 32'(8*k), 0);
        step(0, 0, 1, 2'b11, rnd64(), 32'h120, 0);
        idle(5, 1);

        // steady-state simultaneous push/pop at count 2, pointers wrapping
        step(0, 0, 1, 2'b11, rnd64(), 32'h400, 0);
        step(0, 0, 1, 2'b11, rnd64(), 32'h408, 0);
        for (int k = 0; k < 6; k++) step(0, 0, 1, 2'b11, rnd64(), 32'h410 + 32'(8*k), 1);
        idle(3, 1);

        // flush with a competing push, then a fresh push
        for (int k = 0; k < 3; k++) step(0, 0, 1, 2'b01, rnd64(), 32'h180 + 32'(8*k), 0);
        step(0, 1, 1, 2'b11, rnd64(), 32'h200, 0);
        step(0, 0, 1, 2'b11, rnd64(), 32'h300, 0);
        idle(2, 1);

        // empty-mask bundle dropped; partial mask preserved
        step(0, 0, 1, 2'b00, rnd64(), 32'h500, 0);
        step(0, 0, 1, 2'b10, {32'h00000013, 32'h00100093}, 32'h508, 0);
        idle(1, 0);
        idle(2, 1);

        // reset mid-operation at count 3
        for (int k = 0; k < 3; k++) step(0, 0, 1, 2'b11, rnd64(), 32'h600 + 32'(8*k), 0);
        step(1, 0, 1, 2'b11, rnd64(), 32'h700, 1);
        idle(2, 0);

        // randomized traffic
        for (int k = 0; k < 600; k++) begin
            step(($urandom_range(0, 59) == 0), ($urandom_range(0, 24) == 0),
                 ($urandom_range(0, 9) < 7), 2'($urandom()), rnd64(),
                 32'($urandom()) & 32'hFFFF_FFF8, ($urandom_range(0, 1) == 1));
        end
        idle(6, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
